// File: rtl/text_cmd_writer.sv
// text_cmd_writer: command-side producer for the 8x8 text area.
// Buffers character bytes in a small FIFO, tracks the write cursor with
// wrap-around, and emits a set-cursor word followed by a set-cell word for
// every character, each held for CMD_HOLD command-clock cycles.
// Optional build macro: TEXT_CMD_CTRL_CHARS_EN (LF/CR/BS move the cursor
// instead of being drawn as glyphs).
module text_cmd_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CMD_HOLD    = 2,
  parameter int NUM_COLUMNS = 84,
  parameter int NUM_ROWS    = 64
) (
  input  logic        i_cmd_clk,
  input  logic        i_rst_n,
  input  logic        i_char_valid,
  input  logic [7:0]  i_char,
  output logic        o_char_ready,
  input  logic        i_attr_we,
  input  logic [3:0]  i_attr_fg,
  input  logic [3:0]  i_attr_bg,
  input  logic        i_cursor_we,
  input  logic [5:0]  i_cursor_row,
  input  logic [6:0]  i_cursor_column,
  output logic [31:0] o_cmd_data,
  output logic        o_busy,
  output logic [5:0]  o_cursor_row,
  output logic [6:0]  o_cursor_column
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(CMD_HOLD + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(CMD_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [6:0]    LAST_COL   = 7'(NUM_COLUMNS - 1);
  localparam logic [5:0]    LAST_ROW   = 6'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CURSOR,
    CELL
  } state_t;

  typedef struct packed {
    logic [5:0] row;
    logic [6:0] col;
  } cursor_t;

  // Step one cell to the right, wrapping to the next row and then to (0,0).
  function automatic cursor_t advance(input cursor_t c);
    cursor_t n;
    n = c;
    if (c.col == LAST_COL) begin
      n.col = '0;
      n.row = (c.row == LAST_ROW) ? '0 : c.row + 6'd1;
    end else begin
      n.col = c.col + 7'd1;
    end
    return n;
  endfunction

  function automatic logic [31:0] cursor_word(input cursor_t c);
    return {4'b0111, 6'b0, c.row, 9'b0, c.col};
  endfunction

  function automatic logic [31:0] cell_word(input logic [3:0] fg,
                                            input logic [3:0] bg,
                                            input logic [7:0] ch);
    return {4'b1000, 12'b0, fg, bg, ch};
  endfunction

`ifdef TEXT_CMD_CTRL_CHARS_EN
  // Cursor motion for the recognised control codes.
  function automatic cursor_t ctrl_move(input cursor_t c, input logic [7:0] ch);
    cursor_t n;
    n = c;
    case (ch)
      8'h0A: begin
        n.col = '0;
        n.row = (c.row == LAST_ROW) ? '0 : c.row + 6'd1;
      end
      8'h0D: n.col = '0;
      8'h08: if (c.col != '0) n.col = c.col - 7'd1;
      default: ;
    endcase
    return n;
  endfunction
`endif

  // Character FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, count_nxt;
  logic        empty, push, pop;
  logic [7:0]  head;

  // Control state
  state_t        state, state_nxt;
  logic [HW-1:0] cnt;
  cursor_t       cursor, cursor_nxt;
  logic [3:0]    fg, bg;
  logic          idle_pop, last_cell, chain, cursor_wr, head_is_ctrl;

  // In-flight character, latched at pop time
  logic [7:0] fl_char;
  cursor_t    fl_cur;
  logic [3:0] fl_fg, fl_bg;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign push      = i_char_valid & o_char_ready;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef TEXT_CMD_CTRL_CHARS_EN
  logic ctrl_apply;
  assign head_is_ctrl = (head == 8'h0A) || (head == 8'h0D) || (head == 8'h08);
`else
  assign head_is_ctrl = 1'b0;
`endif

  // FIFO storage write
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops cheaply.
  always_ff @(posedge i_cmd_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_char;
  end

  // FIFO pointers and registered ready (= not full after this edge)
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_cmd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_char_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_char_ready <= (count_nxt != FULL_COUNT);
    end
  end

  // Pop decisions, next cursor and next FSM state
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idle_pop   = (state == IDLE) && !empty;
    last_cell  = (state == CELL) && (cnt == HOLD_LAST);
    chain      = last_cell && !empty && !head_is_ctrl;
    pop        = idle_pop || chain;
    cursor_wr  = i_cursor_we && (i_cursor_column <= LAST_COL);
`ifdef TEXT_CMD_CTRL_CHARS_EN
    ctrl_apply = idle_pop && head_is_ctrl;
`endif

    // Priority: advance, then control-code motion, then an explicit write.
    cursor_nxt = cursor;
    if (last_cell) cursor_nxt = advance(cursor);
`ifdef TEXT_CMD_CTRL_CHARS_EN
    if (ctrl_apply) cursor_nxt = ctrl_move(cursor, head);
`endif
    if (cursor_wr) cursor_nxt = '{row: i_cursor_row, col: i_cursor_column};

    state_nxt = state;
    case (state)
      IDLE:    if (idle_pop && !head_is_ctrl) state_nxt = CURSOR;
      CURSOR:  if (cnt == HOLD_LAST)          state_nxt = CELL;
      CELL:    if (last_cell)                 state_nxt = chain ? CURSOR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cursor and attribute registers
  always_ff @(posedge i_cmd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cursor <= '0;
      fg     <= 4'hF;
      bg     <= 4'h0;
    end else begin
      cursor <= cursor_nxt;
      if (i_attr_we) begin
        fg <= i_attr_fg;
        bg <= i_attr_bg;
      end
    end
  end

  // Command FSM: sequences cursor word then cell word, each CMD_HOLD cycles.
  // Entering CURSOR from IDLE starts at cnt=0, a one-cycle lead-in before
  // the cursor word; chaining from CELL starts at cnt=1 so there is no gap.
  always_ff @(posedge i_cmd_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      o_cmd_data <= '0;
      o_busy     <= 1'b0;
      fl_char    <= '0;
      fl_cur     <= '0;
      fl_fg      <= '0;
      fl_bg      <= '0;
    end else begin
      state  <= state_nxt;
      o_busy <= (count_nxt != '0) || (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (idle_pop && !head_is_ctrl) begin
            fl_char <= head;
            fl_cur  <= cursor;
            fl_fg   <= fg;
            fl_bg   <= bg;
            cnt     <= '0;
          end
        end
        CURSOR: begin
          if (cnt == '0) begin
            o_cmd_data <= cursor_word(fl_cur);
            cnt        <= HOLD_ONE;
          end else if (cnt == HOLD_LAST) begin
            o_cmd_data <= cell_word(fl_fg, fl_bg, fl_char);
            cnt        <= HOLD_ONE;
          end else begin
            cnt <= cnt + HOLD_ONE;
          end
        end
        CELL: begin
          if (last_cell) begin
            if (chain) begin
              fl_char    <= head;
              fl_cur     <= cursor_nxt;
              fl_fg      <= fg;
              fl_bg      <= bg;
              o_cmd_data <= cursor_word(cursor_nxt);
              cnt        <= HOLD_ONE;
            end else begin
              o_cmd_data <= '0;
              cnt        <= '0;
            end
          end else begin
            cnt <= cnt + HOLD_ONE;
          end
        end
        default: begin
          o_cmd_data <= '0;
          cnt        <= '0;
        end
      endcase
    end
  end

  assign o_cursor_row    = cursor.row;
  assign o_cursor_column = cursor.col;

endmodule

// File: tb/tb_text_cmd_writer.sv
// Self-checking bench for text_cmd_writer: directed scenarios followed by
// randomized bursts compared against a word-level reference model.
module tb_text_cmd_writer;

  localparam int HOLD = 2;
  localparam int COLS = 84;
  localparam int ROWS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_char_valid = 1'b0;
  logic [7:0]  i_char = '0;
  logic        o_char_ready;
  logic        i_attr_we = 1'b0;
  logic [3:0]  i_attr_fg = '0;
  logic [3:0]  i_attr_bg = '0;
  logic        i_cursor_we = 1'b0;
  logic [5:0]  i_cursor_row = '0;
  logic [6:0]  i_cursor_column = '0;
  logic [31:0] o_cmd_data;
  logic        o_busy;
  logic [5:0]  o_cursor_row;
  logic [6:0]  o_cursor_column;

  always #5 clk = ~clk;

  text_cmd_writer dut (
    .i_cmd_clk       (clk),
    .i_rst_n         (rst_n),
    .i_char_valid    (i_char_valid),
    .i_char          (i_char),
    .o_char_ready    (o_char_ready),
    .i_attr_we       (i_attr_we),
    .i_attr_fg       (i_attr_fg),
    .i_attr_bg       (i_attr_bg),
    .i_cursor_we     (i_cursor_we),
    .i_cursor_row    (i_cursor_row),
    .i_cursor_column (i_cursor_column),
    .o_cmd_data      (o_cmd_data),
    .o_busy          (o_busy),
    .o_cursor_row    (o_cursor_row),
    .o_cursor_column (o_cursor_column)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word monitor: records every non-zero word together with how many cycles it was held.
  typedef struct {
    logic [31:0] word;
    int          run;
  } obs_t;
  obs_t        obs_q[$];
  logic [31:0] mon_last = '0;
  int          mon_run = 0;
  logic        saw_full = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_last = '0;
      mon_run  = 0;
    end else if (o_cmd_data !== mon_last) begin
      if (mon_last != 0) obs_q.push_back('{word: mon_last, run: mon_run});
      mon_last = o_cmd_data;
      mon_run  = 1;
    end else begin
      mon_run++;
    end
    if (rst_n && !o_char_ready) saw_full = 1'b1;
  end

  // Reference model: cursor/attribute state and the expected word stream.
  int          m_row = 0, m_col = 0;
  logic [3:0]  m_fg = 4'hF, m_bg = 4'h0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] cur_word(input int r, input int c);
    return 32'(32'h7000_0000 + r * 65536 + c);
  endfunction

  function automatic logic [31:0] cel_word(input logic [3:0] f, input logic [3:0] b,
                                           input logic [7:0] ch);
    return 32'(32'h8000_0000 + int'(f) * 4096 + int'(b) * 256 + int'(ch));
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_fg = 4'hF; m_bg = 4'h0;
  endtask

  task automatic model_char(input logic [7:0] ch);
`ifdef TEXT_CMD_CTRL_CHARS_EN
    if (ch == 8'h0A) begin m_col = 0; m_row = (m_row + 1) % ROWS; return; end
    if (ch == 8'h0D) begin m_col = 0; return; end
    if (ch == 8'h08) begin if (m_col > 0) m_col--; return; end
`endif
    exp_q.push_back(cur_word(m_row, m_col));
    exp_q.push_back(cel_word(m_fg, m_bg, ch));
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end
  endtask

  task automatic set_attr(input logic [3:0] f, input logic [3:0] b);
    @(negedge clk);
    i_attr_we = 1'b1; i_attr_fg = f; i_attr_bg = b;
    @(negedge clk);
    i_attr_we = 1'b0;
    m_fg = f; m_bg = b;
  endtask

  task automatic set_cursor(input int r, input int c);
    @(negedge clk);
    i_cursor_we = 1'b1; i_cursor_row = 6'(r); i_cursor_column = 7'(c);
    @(negedge clk);
    i_cursor_we = 1'b0;
    if (c < COLS) begin m_row = r; m_col = c; end
  endtask

  // Offer a byte and hold valid until the edge that accepts it.
  task automatic push_char(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    i_char_valid = 1'b1; i_char = c;
    while (!o_char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("push_timeout", 32'(n), 32'(0));
    @(posedge clk);
    model_char(c);
  endtask

  task automatic end_push();
    @(negedge clk);
    i_char_valid = 1'b0;
  endtask

  // Wait (bounded) for a non-zero word; returns the number of cycles waited.
  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (o_cmd_data == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 60), 32'(1));
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    for (int k = 0; k < HOLD; k++) begin
      check(tag, o_cmd_data, exp);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 500), 32'(1));
    @(negedge clk);
  endtask

  function automatic logic [31:0] cur_pos();
    return 32'(int'(o_cursor_row) * 256 + int'(o_cursor_column));
  endfunction

  function automatic logic [31:0] pos(input int r, input int c);
    return 32'(r * 256 + c);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;

    // Reset state
    #12;
    check("rst_cmd", o_cmd_data, 32'h0);
    check("rst_ready", 32'(o_char_ready), 32'(1));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_cursor", cur_pos(), pos(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single character, exact latency and framing
    set_attr(4'hF, 4'h1);
    push_char(8'h41);
    end_push();
    check("t1_busy", 32'(o_busy), 32'(1));
    wait_start("t1_start", n);
    check("t1_latency", 32'(n), 32'(2));
    check("t1_busy_word", 32'(o_busy), 32'(1));
    expect_word("t1_cursor", 32'h7000_0000);
    expect_word("t1_cell", 32'h8000_F141);
    check("t1_gap", o_cmd_data, 32'h0);
    check("t1_pos", cur_pos(), pos(0, 1));
    check("t1_idle", 32'(o_busy), 32'(0));

    // Back-to-back characters across the column wrap
    set_cursor(5, 83);
    push_char(8'h42);
    push_char(8'h43);
    end_push();
    wait_start("t2_start", n);
    expect_word("t2_w0", 32'h7005_0053);
    expect_word("t2_w1", 32'h8000_F142);
    expect_word("t2_w2", 32'h7006_0000);
    expect_word("t2_w3", 32'h8000_F143);
    check("t2_gap", o_cmd_data, 32'h0);
    check("t2_pos", cur_pos(), pos(6, 1));

    // Full wrap to (0,0) and an out-of-range cursor write
    set_cursor(63, 83);
    push_char(8'h20);
    end_push();
    wait_start("t3_start", n);
    expect_word("t3_cursor", 32'h703F_0053);
    expect_word("t3_cell", 32'h8000_F120);
    check("t3_pos", cur_pos(), pos(0, 0));
    set_cursor(7, 84);
    check("t3_badwrite", cur_pos(), pos(0, 0));

    // Eight characters with valid held high: back-pressure, order, no gaps
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) push_char(8'(8'h50 + i));
        end_push();
      end
      begin
        int m;
        wait_start("t4_start", m);
        for (int i = 0; i < 8; i++) begin
          expect_word("t4_cursor", cur_word(0, i));
          expect_word("t4_cell", cel_word(4'hF, 4'h1, 8'(8'h50 + i)));
        end
      end
    join
    check("t4_gap", o_cmd_data, 32'h0);
    check("t4_saw_full", 32'(saw_full), 32'(1));
    check("t4_pos", cur_pos(), pos(0, 8));

    // Asynchronous reset during the second cycle of a cell word
    push_char(8'h41);
    end_push();
    wait_start("t5_start", n);
    repeat (3) @(negedge clk);
    check("t5_pre_cell", 32'(o_cmd_data[31:28]), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cmd", o_cmd_data, 32'h0);
    check("t5_pos", cur_pos(), pos(0, 0));
    check("t5_ready", 32'(o_char_ready), 32'(1));
    check("t5_busy", 32'(o_busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    push_char(8'h41);
    end_push();
    wait_start("t5_restart", n);
    expect_word("t5_cursor", 32'h7000_0000);
    expect_word("t5_cell", 32'h8000_F041);
    check("t5_pos2", cur_pos(), pos(0, 1));

    // Line feed: control code or glyph depending on the build
    set_cursor(2, 10);
    push_char(8'h0A);
    end_push();
`ifdef TEXT_CMD_CTRL_CHARS_EN
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_cmd_data != 0) seen = 1'b1;
    end
    check("t6_no_words", 32'(seen), 32'(0));
    check("t6_pos", cur_pos(), pos(3, 0));
`else
    seen = 1'b0;
    wait_start("t6_start", n);
    expect_word("t6_cursor", 32'h7002_000A);
    expect_word("t6_cell", 32'h8000_F00A);
    check("t6_pos", cur_pos(), pos(2, 11));
    check("t6_seen", 32'(seen), 32'(0));
`endif

    // Randomized bursts against the reference model
    wait_idle("rnd_idle0");
    obs_q.delete();
    exp_q.delete();
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 1) == 1)
        set_attr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1)
          set_cursor($urandom_range(60, 63), $urandom_range(78, 90));
        else
          set_cursor($urandom_range(0, 63), $urandom_range(0, 90));
        check("rnd_setpos", cur_pos(), pos(m_row, m_col));
      end
      for (int k = 0, len = $urandom_range(1, 9); k < len; k++) begin
        push_char(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 9) < 3) begin
          end_push();
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end
      end_push();
      wait_idle("rnd_idle");
      check("rnd_nwords", 32'(obs_q.size()), 32'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        obs_t o;
        logic [31:0] e;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        check("rnd_word", o.word, e);
        check("rnd_hold", 32'(o.run), 32'(HOLD));
      end
      obs_q.delete();
      exp_q.delete();
      check("rnd_pos", cur_pos(), pos(m_row, m_col));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
